// File: rtl/gemm_ws_stream_array_pkg.sv
// Shared types and sizing helpers for the weight-stationary streaming GEMM array.
package gemm_ws_stream_array_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDrain
  } gemm_ws_state_t;

  // Accept-to-result latency of an n x n array, including skew and deskew.
  function automatic int unsigned gemm_ws_latency(input int unsigned n);
    return 2 * n;
  endfunction

  // In-flight counter width: the count ranges over 0..2n inclusive.
  function automatic int unsigned gemm_ws_cnt_width(input int unsigned n);
    return $clog2(2 * n + 1);
  endfunction

endpackage

// File: rtl/gemm_ws_stream_array_pe.sv
// One multiply-accumulate cell: activation passes right, partial sum passes down.
module gemm_ws_pe
  import gemm_ws_stream_array_pkg::*;
#(
  parameter int unsigned WA_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH = 20,
  parameter bit          SIGNED    = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [WA_WIDTH-1:0]  act_in,
  input  logic [WA_WIDTH-1:0]  weight,
  input  logic [ACC_WIDTH-1:0] psum_in,
  output logic [WA_WIDTH-1:0]  act_out,
  output logic [ACC_WIDTH-1:0] psum_out
);

  logic [ACC_WIDTH-1:0] act_ext;
  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH-1:0] psum_d;

  // Extend both operands to accumulator width, then MAC modulo 2^ACC_WIDTH
  always_comb begin
    if (SIGNED) begin
      act_ext = ACC_WIDTH'($signed(act_in));
      w_ext   = ACC_WIDTH'($signed(weight));
    end else begin
      act_ext = ACC_WIDTH'(act_in);
      w_ext   = ACC_WIDTH'(weight);
    end
    psum_d = psum_in + act_ext * w_ext;
  end

  // Register activation and partial sum; hold while the array is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      act_out  <= '0;
      psum_out <= '0;
    end else if (en) begin
      act_out  <= act_in;
      psum_out <= psum_d;
    end
  end

endmodule

// File: rtl/gemm_ws_stream_array.sv
// Weight-stationary systolic GEMM: out = in x W with runtime weight loading,
// internal skew/deskew and a global stall on output backpressure.
module gemm_ws_stream_array
  import gemm_ws_stream_array_pkg::*;
#(
  parameter int unsigned SA_SIZE   = 4,
  parameter int unsigned WA_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH = 20,
  parameter bit          SIGNED    = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic [SA_SIZE*WA_WIDTH-1:0]  w_row,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SA_SIZE*WA_WIDTH-1:0]  in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SA_SIZE*ACC_WIDTH-1:0] out_data,
  output logic                         weights_loaded,
  output logic                         busy
);

  localparam int unsigned Lat  = gemm_ws_latency(SA_SIZE);
  localparam int unsigned CntW = gemm_ws_cnt_width(SA_SIZE);
  localparam int unsigned RowW = $clog2(SA_SIZE);

  typedef logic [WA_WIDTH-1:0]  wa_t;
  typedef logic [ACC_WIDTH-1:0] acc_t;

  gemm_ws_state_t  state_q, state_d;
  logic [RowW-1:0] row_cnt_q;
  logic [CntW-1:0] cnt_q;
  logic [Lat-1:0]  valid_q;
  logic            weights_loaded_q;
  wa_t             weight_q [SA_SIZE][SA_SIZE];

  logic stall, en, w_acc, in_acc, out_acc, row_last;

  assign out_valid      = valid_q[Lat-1];
  assign stall          = out_valid && !out_ready;
  assign en             = !stall;
  assign w_acc          = w_valid && w_ready;
  assign in_acc         = in_valid && in_ready;
  assign out_acc        = out_valid && out_ready;
  assign row_last       = (row_cnt_q == RowW'(SA_SIZE - 1));
  assign busy           = (cnt_q != '0);
  assign weights_loaded = weights_loaded_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next state: load all rows, run, drain in-flight vectors before reloading
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (w_acc) state_d = StLoad;
      StLoad:  if (w_acc && row_last) state_d = StRun;
      StRun:   if (w_valid) state_d = StDrain;
      StDrain: if (cnt_q == '0) state_d = StLoad;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs; both forced low while reset is asserted
  always_comb begin
    w_ready  = 1'b0;
    in_ready = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StIdle, StLoad: w_ready  = 1'b1;
        StRun:          in_ready = !stall;
        default:        ;
      endcase
    end
  end

  // Weight rows, row counter and the resident-matrix flag
  always_ff @(posedge clk) begin
    if (reset) begin
      row_cnt_q        <= '0;
      weights_loaded_q <= 1'b0;
      for (int k = 0; k < SA_SIZE; k++) begin
        for (int j = 0; j < SA_SIZE; j++) weight_q[k][j] <= '0;
      end
    end else begin
      if (w_acc) begin
        for (int j = 0; j < SA_SIZE; j++) begin
          weight_q[row_cnt_q][j] <= w_row[j*WA_WIDTH +: WA_WIDTH];
        end
        row_cnt_q <= row_last ? '0 : row_cnt_q + 1'b1;
      end
      if (state_q == StLoad && w_acc && row_last) begin
        weights_loaded_q <= 1'b1;
      end else if (state_q == StDrain && cnt_q == '0) begin
        weights_loaded_q <= 1'b0;
      end
    end
  end

  // In-flight count and valid pipe; the pipe shifts only when not stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(in_acc) - CntW'(out_acc);
      if (en) valid_q <= {valid_q[Lat-2:0], in_acc};
    end
  end

  wa_t  act_w  [SA_SIZE][SA_SIZE];
  acc_t psum_w [SA_SIZE+1][SA_SIZE];

  for (genvar k = 0; k < SA_SIZE; k++) begin : g_skew
    wa_t sk_q [k+1];

    // Row k enters k cycles after row 0; bubbles inject zeros
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int d = 0; d <= k; d++) sk_q[d] <= '0;
      end else if (en) begin
        sk_q[0] <= in_acc ? in_data[k*WA_WIDTH +: WA_WIDTH] : '0;
        for (int d = 1; d <= k; d++) sk_q[d] <= sk_q[d-1];
      end
    end

    assign act_w[k][0] = sk_q[k];
  end

  for (genvar j = 0; j < SA_SIZE; j++) begin : g_top
    assign psum_w[0][j] = '0;
  end

  for (genvar k = 0; k < SA_SIZE; k++) begin : g_row
    for (genvar j = 0; j < SA_SIZE; j++) begin : g_col
      wa_t act_o;

      gemm_ws_pe #(
        .WA_WIDTH  (WA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .SIGNED    (SIGNED)
      ) u_pe (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .act_in   (act_w[k][j]),
        .weight   (weight_q[k][j]),
        .psum_in  (psum_w[k][j]),
        .act_out  (act_o),
        .psum_out (psum_w[k+1][j])
      );

      if (j < SA_SIZE - 1) begin : g_pass
        assign act_w[k][j+1] = act_o;
      end else begin : g_edge
        wa_t act_unused;
        assign act_unused = act_o;
      end
    end
  end

  for (genvar j = 0; j < SA_SIZE; j++) begin : g_deskew
    localparam int unsigned Dly = SA_SIZE - 1 - j;

    if (Dly == 0) begin : g_direct
      assign out_data[j*ACC_WIDTH +: ACC_WIDTH] = psum_w[SA_SIZE][j];
    end else begin : g_delay
      acc_t ds_q [Dly];

      // Column j leaves the array Dly cycles early; delay it to line up
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int d = 0; d < Dly; d++) ds_q[d] <= '0;
        end else if (en) begin
          ds_q[0] <= psum_w[SA_SIZE][j];
          for (int d = 1; d < Dly; d++) ds_q[d] <= ds_q[d-1];
        end
      end

      assign out_data[j*ACC_WIDTH +: ACC_WIDTH] = ds_q[Dly-1];
    end
  end

endmodule

// File: tb/tb_gemm_ws_stream_array.sv
// Bench for gemm_ws_stream_array: scoreboarded 2x2 unsigned array, plus
// signed/16-bit and unsigned/8-bit instances for extension and wrap checks.
module tb_gemm_ws_stream_array;

  typedef logic [1:0][1:0][7:0] mat_t;
  typedef struct {
    logic [31:0] data;
    int          cyc;
    int          stalls;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        w_valid, w_ready, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] w_row, in_data;
  logic [31:0] out_data;
  logic        weights_loaded, busy;

  logic        s_w_valid, s_in_valid, s_out_ready;
  logic [15:0] s_w_row, s_in_data;
  logic        s_w_ready, s_in_ready, s_out_valid, s_loaded, s_busy;
  logic [31:0] s_out_data;
  logic        u_w_ready, u_in_ready, u_out_valid, u_loaded, u_busy;
  logic [15:0] u_out_data;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  mat_t cur_w = '0;
  exp_t sb[$];
  bit   rand_ready = 1'b0;

  gemm_ws_stream_array #(
    .SA_SIZE(2), .WA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(1'b0)
  ) u_dut (
    .clk(clk), .reset(reset), .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .weights_loaded(weights_loaded), .busy(busy)
  );

  gemm_ws_stream_array #(
    .SA_SIZE(2), .WA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(1'b1)
  ) u_dut_signed (
    .clk(clk), .reset(reset), .w_valid(s_w_valid), .w_ready(s_w_ready), .w_row(s_w_row),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .weights_loaded(s_loaded), .busy(s_busy)
  );

  gemm_ws_stream_array #(
    .SA_SIZE(2), .WA_WIDTH(8), .ACC_WIDTH(8), .SIGNED(1'b0)
  ) u_dut_wrap (
    .clk(clk), .reset(reset), .w_valid(s_w_valid), .w_ready(u_w_ready), .w_row(s_w_row),
    .in_valid(s_in_valid), .in_ready(u_in_ready), .in_data(s_in_data),
    .out_valid(u_out_valid), .out_ready(s_out_ready), .out_data(u_out_data),
    .weights_loaded(u_loaded), .busy(u_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: unsigned 2x2 product, each column modulo 2^16
  function automatic logic [31:0] model(input logic [15:0] v, input mat_t w);
    logic [15:0] acc;
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 2; j++) begin
      acc = '0;
      for (int k = 0; k < 2; k++) acc += 16'(v[k*8 +: 8]) * 16'(w[k][j]);
      r[j*16 +: 16] = acc;
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Scoreboard monitor on the falling edge, where all handshakes are settled
  initial begin : monitor
    exp_t        e;
    bit          was_stall;
    logic [31:0] held;
    was_stall = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        was_stall = 1'b0;
      end else begin
        if (was_stall) check_eq("hold_data", out_data, held);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check_eq("no_stale_out", 32'(out_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            check_eq("out_data", out_data, e.data);
            check_eq("latency", 32'(cyc - e.cyc), 32'(4 + stall_cnt - e.stalls));
          end
        end
        was_stall = out_valid && !out_ready;
        if (was_stall) begin
          check_eq("in_ready_stall", 32'(in_ready), 32'd0);
          held = out_data;
          stall_cnt++;
        end
        if (in_valid && in_ready) sb.push_back('{model(in_data, cur_w), cyc, stall_cnt});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_w(input mat_t m);
    bit ok;
    for (int k = 0; k < 2; k++) begin
      ok = 1'b0;
      w_valid = 1'b1;
      w_row = m[k];
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (w_ready) begin
          ok = 1'b1;
          break;
        end
      end
      check_eq("w_accept", 32'(ok), 32'd1);
      tick();
    end
    w_valid = 1'b0;
    cur_w = m;
  endtask

  task automatic send(input logic [15:0] v);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = v;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("in_accept", 32'(ok), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check_eq("drained", 32'(busy), 32'd0);
    tick();
  endtask

  task automatic s_load(input mat_t m);
    bit ok;
    for (int k = 0; k < 2; k++) begin
      ok = 1'b0;
      s_w_valid = 1'b1;
      s_w_row = m[k];
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (s_w_ready) begin
          ok = 1'b1;
          break;
        end
      end
      check_eq("s_w_accept", 32'(ok), 32'd1);
      tick();
    end
    s_w_valid = 1'b0;
  endtask

  task automatic s_run(input logic [15:0] v, input logic [31:0] exp_s, input logic [15:0] exp_u);
    bit ok;
    ok = 1'b0;
    s_in_valid = 1'b1;
    s_in_data = v;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("s_in_accept", 32'(ok), 32'd1);
    tick();
    s_in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("s_out_seen", 32'(ok), 32'd1);
    check_eq("signed_out", s_out_data, exp_s);
    check_eq("wrap_valid", 32'(u_out_valid), 32'd1);
    check_eq("wrap_out", 32'(u_out_data), 32'(exp_u));
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    reset = 1'b1;
    w_valid = 1'b0; w_row = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    s_w_valid = 1'b0; s_w_row = '0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_loaded", 32'(weights_loaded), 32'd0);
    check_eq("rst_w_ready", 32'(w_ready), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle_w_ready", 32'(w_ready), 32'd1);
    check_eq("idle_in_ready", 32'(in_ready), 32'd0);
    tick();

    // W0=[3,0], W1=[0,2]; single vector then a back-to-back pair
    load_w({8'd2, 8'd0, 8'd0, 8'd3});
    check_eq("loaded", 32'(weights_loaded), 32'd1);
    check_eq("run_in_ready", 32'(in_ready), 32'd1);
    check_eq("run_w_ready", 32'(w_ready), 32'd0);
    send({8'd5, 8'd2});
    wait_idle();
    send({8'd5, 8'd2});
    send({8'd2, 8'd3});
    wait_idle();

    // Backpressure: hold the first result for three cycles
    out_ready = 1'b0;
    send({8'd5, 8'd2});
    send({8'd2, 8'd3});
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("bp_out_seen", 32'(ok), 32'd1);
    check_eq("bp_first", out_data, {16'd10, 16'd6});
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();

    // Reload with two vectors in flight
    send({8'd5, 8'd2});
    send({8'd2, 8'd3});
    w_valid = 1'b1;
    w_row = {8'd2, 8'd1};
    tick();
    check_eq("drain_in_ready", 32'(in_ready), 32'd0);
    check_eq("drain_busy", 32'(busy), 32'd1);
    check_eq("drain_loaded", 32'(weights_loaded), 32'd1);
    load_w({8'd4, 8'd3, 8'd2, 8'd1});
    check_eq("reloaded", 32'(weights_loaded), 32'd1);
    send({8'd5, 8'd2});
    wait_idle();

    // Random weights and vectors with random gaps and random backpressure
    load_w(mat_t'($urandom()));
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send(16'($urandom()));
    end
    rand_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    wait_idle();

    // Signed extension (16-bit) and unsigned wrap (8-bit)
    s_load({8'd4, 8'd2, 8'hFF, 8'd3});
    s_run({8'd2, 8'hFF}, {16'd9, 16'd1}, {8'd9, 8'd1});
    s_load({8'd5, 8'd0, 8'd0, 8'd16});
    s_run({8'd3, 8'd16}, {16'd15, 16'd256}, {8'd15, 8'd0});

    // Reset with three vectors in flight
    send({8'd5, 8'd2});
    send({8'd2, 8'd3});
    send({8'd1, 8'd1});
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    check_eq("post_rst_loaded", 32'(weights_loaded), 32'd0);
    check_eq("post_rst_out_data", out_data, 32'd0);
    repeat (12) @(negedge clk);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
